// File: rtl/mux_memoria_rr_param_pkg.sv
// Shared constants for the N-channel registered mux: selection-mode encodings and default geometry.
package mux_memoria_rr_param_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_N     = 4;
  localparam int DEF_SEL_W = 2;

endpackage

// File: rtl/mux_memoria_rr_param_rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N-1.
module mux_memoria_rr_param_rr_arbiter_n
  import mux_memoria_rr_param_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  localparam logic [SEL_W:0] NW = (SEL_W+1)'(N);

  logic [SEL_W:0] w_pos;
  logic           w_found;

  // Scan from the farthest offset back to ptr so the nearest requester is the last to write.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + (SEL_W+1)'(k);
      if (w_pos >= NW) w_pos = w_pos - NW;
      if (req[w_pos[SEL_W-1:0]]) begin
        gnt_idx = w_pos[SEL_W-1:0];
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) gnt[i] = w_found && (gnt_idx == SEL_W'(i));
  end

endmodule

// File: rtl/mux_memoria_rr_param.sv
// N-channel registered mux with output memory, valid/ready handshakes and
// external-selector or round-robin channel selection.
module mux_memoria_rr_param
  import mux_memoria_rr_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               mode,
  input  logic [SEL_W-1:0]   selector,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [N-1:0]       valid_in,
  output logic [N-1:0]       ready_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [SEL_W-1:0]   sel_out,
  output logic               err_sel
);

  localparam int             NP = 1 << SEL_W;
  localparam logic [SEL_W:0] NW = (SEL_W+1)'(N);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic             r_err;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [NP-1:0]    w_vin_ext;
  logic             w_sel_ok;
  logic             w_sel_gnt;
  logic [N-1:0]     w_sel_oh;
  logic [N-1:0]     w_arb_gnt;
  logic [SEL_W-1:0] w_arb_idx;
  logic [N-1:0]     w_gnt_oh;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_have;
  logic             w_space;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;

  mux_memoria_rr_param_rr_arbiter_n #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (valid_in),
    .ptr     (r_rr_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx)
  );

  // Padding lets an out-of-range selector index valid_in safely.
  assign w_vin_ext = NP'(valid_in);
  assign w_sel_ok  = ({1'b0, selector} < NW);
  assign w_sel_gnt = w_sel_ok && w_vin_ext[selector];

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < N; i++) w_sel_oh[i] = w_sel_gnt && (selector == SEL_W'(i));
  end

  assign w_gnt_oh  = (mode == MODE_RR) ? w_arb_gnt : w_sel_oh;
  assign w_gnt_idx = (mode == MODE_RR) ? w_arb_idx : selector;
  assign w_have    = |w_gnt_oh;
  assign w_space   = !r_valid || ready_out;
  assign w_accept  = w_space && w_have;
  assign ready_in  = (reset_L && w_accept) ? w_gnt_oh : '0;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++)
      if (w_gnt_idx == SEL_W'(i)) w_data = data_in[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_sel    <= '0;
      r_err    <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= w_data;
        r_sel   <= w_gnt_idx;
        r_valid <= 1'b1;
      end else if (ready_out) begin
        r_valid <= 1'b0;
      end
      if (w_accept && (mode == MODE_RR))
        r_rr_ptr <= (w_gnt_idx == SEL_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
      r_err <= (mode == MODE_SEL) && !w_sel_ok && (|valid_in);
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign sel_out   = r_sel;
  assign err_sel   = r_err;

endmodule

// File: tb/tb_mux_memoria_rr_param.sv
// Scoreboard bench: an N=4 and an N=3 instance share one stimulus stream; each has its own model.
module tb_mux_memoria_rr_param;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       mode;
  logic [1:0] selector;
  logic [7:0] data_in;
  logic [3:0] valid_in;
  logic       ready_out;

  logic [3:0] ready_in0;
  logic [1:0] dout0, sel0;
  logic       vout0, err0;
  logic [2:0] ready_in1;
  logic [1:0] dout1, sel1;
  logic       vout1, err1;

  int n_vec = 0;
  int n_err = 0;

  bit         m_vout[2];
  logic [1:0] m_dout[2];
  int         m_sel[2];
  int         m_ptr[2];
  bit         m_err[2];
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  mux_memoria_rr_param #(.WIDTH(2), .N(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in0),
    .data_out(dout0), .valid_out(vout0), .ready_out(ready_out),
    .sel_out(sel0), .err_sel(err0)
  );

  mux_memoria_rr_param #(.WIDTH(2), .N(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
    .data_in(data_in[5:0]), .valid_in(valid_in[2:0]), .ready_in(ready_in1),
    .data_out(dout1), .valid_out(vout1), .ready_out(ready_out),
    .sel_out(sel1), .err_sel(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int grant_of(int n, bit md, int sel, logic [3:0] vin, int ptr);
    if (!md) return (sel < n && vin[sel]) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (vin[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_vout[u] = 0; m_dout[u] = 2'b00; m_sel[u] = 0; m_ptr[u] = 0; m_err[u] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(input string t);
    chk({t, " u4 data_out"}, dout0, 0);
    chk({t, " u4 valid_out"}, vout0, 0);
    chk({t, " u4 sel_out"}, sel0, 0);
    chk({t, " u4 err_sel"}, err0, 0);
    chk({t, " u4 ready_in"}, ready_in0, 0);
    chk({t, " u3 data_out"}, dout1, 0);
    chk({t, " u3 valid_out"}, vout1, 0);
    chk({t, " u3 sel_out"}, sel1, 0);
    chk({t, " u3 ready_in"}, ready_in1, 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit md, input int sel, input logic [7:0] din,
                     input logic [3:0] vin, input bit rdy);
    int         g[2];
    bit         acc[2];
    int         n;
    logic [3:0] vm, got_r, w, got_w;
    mode = md; selector = sel[1:0]; data_in = din; valid_in = vin; ready_out = rdy;
    #1;
    for (int u = 0; u < 2; u++) begin
      n  = (u == 0) ? 4 : 3;
      vm = (u == 0) ? vin : {1'b0, vin[2:0]};
      g[u]   = grant_of(n, md, sel, vm, m_ptr[u]);
      acc[u] = (!m_vout[u] || rdy) && (g[u] >= 0);
      got_r  = (u == 0) ? ready_in0 : {1'b0, ready_in1};
      chk($sformatf("u%0d ready_in", n), got_r, acc[u] ? (32'd1 << g[u]) : 32'd0);
      if (m_vout[u] && rdy) begin
        w = 4'bxxxx;
        if (u == 0 && q0.size() > 0) w = q0.pop_front();
        if (u == 1 && q1.size() > 0) w = q1.pop_front();
        got_w = (u == 0) ? {sel0, dout0} : {sel1, dout1};
        chk($sformatf("u%0d consumed {sel,data}", n), got_w, w);
      end
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      n  = (u == 0) ? 4 : 3;
      vm = (u == 0) ? vin : {1'b0, vin[2:0]};
      if (acc[u]) begin
        m_dout[u] = din[g[u]*2 +: 2];
        m_sel[u]  = g[u];
        m_vout[u] = 1;
        if (u == 0) q0.push_back({2'(g[u]), m_dout[u]});
        else        q1.push_back({2'(g[u]), m_dout[u]});
        if (md) m_ptr[u] = (g[u] == n - 1) ? 0 : g[u] + 1;
      end else if (rdy) begin
        m_vout[u] = 0;
      end
      m_err[u] = !md && (sel >= n) && (|vm);
    end
    #1;
    chk("u4 valid_out", vout0, m_vout[0]);
    chk("u4 data_out", dout0, m_dout[0]);
    chk("u4 sel_out", sel0, m_sel[0]);
    chk("u4 err_sel", err0, m_err[0]);
    chk("u3 valid_out", vout1, m_vout[1]);
    chk("u3 data_out", dout1, m_dout[1]);
    chk("u3 sel_out", sel1, m_sel[1]);
    chk("u3 err_sel", err1, m_err[1]);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
  task automatic mid_reset();
    #2 reset_L = 1'b0;
    #1 chk_zero("async reset");
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; mode = 1'b0; selector = 2'd0;
    data_in = 8'hff; valid_in = 4'hf; ready_out = 1'b1;
    model_reset();
    @(posedge clk);
    #1 chk_zero("power-on reset");
    @(negedge clk);
    reset_L = 1'b1;

    // Mode 0: channel 2 carries 2'b11, then inputs go idle and data_out is remembered.
    cyc(0, 2, 8'h30, 4'b0100, 1);
    cyc(0, 2, 8'h30, 4'b0000, 1);
    cyc(0, 2, 8'h00, 4'b0000, 1);
    cyc(0, 0, 8'h02, 4'b0001, 1);

    // Round robin over all channels, then a sparse pattern from rr_ptr=2.
    mid_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h1b + 8'(i * 37), 4'hf, 1);
    cyc(1, 0, 8'h9c, 4'b1001, 1);
    cyc(1, 0, 8'h63, 4'b1001, 1);

    // Backpressure then release with simultaneous consume and load.
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h5a + 8'(i), 4'hf, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'hc6 + 8'(i * 11), 4'hf, 1);

    // Selector 3: valid for the N=4 build, out of range for the N=3 build.
    cyc(0, 3, 8'hb4, 4'hf, 1);
    cyc(0, 3, 8'hb4, 4'hf, 1);
    cyc(0, 3, 8'h00, 4'h0, 1);
    cyc(0, 3, 8'h00, 4'h0, 1);

    // Mode switch 1 -> 0 -> 1 keeps rr_ptr.
    cyc(1, 0, 8'h39, 4'hf, 1);
    cyc(0, 1, 8'h39, 4'hf, 1);
    cyc(0, 1, 8'h39, 4'hf, 1);
    cyc(1, 1, 8'h8d, 4'hf, 1);
    cyc(1, 1, 8'h72, 4'hf, 1);

    // Reset while a word is held, then the first round-robin grant starts at 0.
    cyc(1, 0, 8'he1, 4'hf, 0);
    mid_reset();
    cyc(1, 0, 8'h4e, 4'b1111, 1);
    cyc(1, 0, 8'h4e, 4'b0110, 1);

    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3), 8'($urandom),
          4'($urandom), ($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
